// File: rtl/keypad_event_queue_if.sv
// CPU-side bus of the keypad event queue: raw key pins, bank-select/load strobes, read data and irq.
interface keypad_event_queue_if;
   logic [7:0]  keypad;
   logic        en;
   logic        memRead;
   logic        addrSel;
   logic [31:0] rdata;
   logic        irq;

   modport master (
      output keypad,
      output en,
      output memRead,
      output addrSel,
      input  rdata,
      input  irq
   );

   modport slave (
      input  keypad,
      input  en,
      input  memRead,
      input  addrSel,
      output rdata,
      output irq
   );
endinterface

// File: rtl/keypad_event_queue.sv
// Keypad stage: 2-flop sync, per-line debounce, edge events into a FIFO popped by CPU DATA loads.
// Release events exist only when KEYPAD_RELEASE_EVENTS_EN is defined; otherwise only presses are queued.
module keypad_event_queue #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned CNT_W           = 4
) (
   input  logic                 slowClk,
   input  logic                 reset,
   keypad_event_queue_if.slave  bus
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_RELEASE_EVENTS_EN
   localparam int unsigned NPEND   = 16;
`else
   localparam int unsigned NPEND   = 8;
`endif
   localparam int unsigned SEL_W   = $clog2(NPEND);

   logic [7:0]        sync1_q, sync1_d;
   logic [7:0]        sync2_q, sync2_d;
   logic [7:0]        stable_q, stable_d;
   logic [7:0][7:0]   cnt_q, cnt_d;
   logic [NPEND-1:0]  pend_q, pend_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        mem_q [FIFO_DEPTH];

   logic [7:0]        rise;
   logic [NPEND-1:0]  pend_set;
   logic [NPEND-1:0]  pend_clr;
   logic [SEL_W-1:0]  sel_idx;
   logic [7:0]        push_code;
   logic              push_req;
   logic              empty;
   logic              full;
   logic              pop;
   logic              push;
   logic              drop;
   logic              stat_rd;
   logic [31:0]       rdata;

   // Debounce: a line must disagree with its stable value for DEBOUNCE_CYCLES
   // consecutive samples of sync2 before the stable value flips.
   always_comb begin
      sync1_d  = bus.keypad;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < 8; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = 8'd0;
         end else if (cnt_q[i] == DB_LAST) begin
            cnt_d[i]    = 8'd0;
            stable_d[i] = ~stable_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   assign rise = stable_d & ~stable_q;

`ifdef KEYPAD_RELEASE_EVENTS_EN
   logic [7:0] fall;
   assign fall     = ~stable_d & stable_q;
   assign pend_set = {fall, rise};
`else
   assign pend_set = rise;
`endif

   // Lowest set pending bit wins; presses occupy the low half so they beat releases.
   always_comb begin
      sel_idx = '0;
      for (int i = NPEND - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel_idx = SEL_W'(i);
         end
      end
   end

   assign push_req = |pend_q;

`ifdef KEYPAD_RELEASE_EVENTS_EN
   assign push_code = {sel_idx[3], 4'b0000, sel_idx[2:0]};
`else
   assign push_code = {5'b00000, sel_idx};
`endif

   always_comb begin
      pend_clr = '0;
      if (push_req) begin
         pend_clr[sel_idx] = 1'b1;
      end
      pend_d = (pend_q & ~pend_clr) | pend_set;
   end

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop     = bus.en & bus.memRead & ~bus.addrSel & ~empty;
   assign stat_rd = bus.en & bus.memRead & bus.addrSel;
   // A pop in the same cycle frees the slot, so a full queue still accepts the push.
   assign push    = push_req & (~full | pop);
   assign drop    = push_req & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (drop) begin
         ovf_d = 1'b1;
      end else if (stat_rd) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge slowClk) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
         pend_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: reads are masked by count.
   always_ff @(posedge slowClk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= push_code;
      end
   end

   always_comb begin
      rdata = '0;
      if (bus.en) begin
         if (!bus.addrSel) begin
            if (!empty) begin
               rdata[7:0] = mem_q[rd_ptr_q];
            end
            rdata[8] = ~empty;
         end else begin
            rdata[CNT_W-1:0] = count_q;
            rdata[15:8]      = stable_q;
            rdata[16]        = ovf_q;
         end
      end
   end

   assign bus.rdata = rdata;
   assign bus.irq   = ~empty;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed plus randomized bench for keypad_event_queue with DEBOUNCE_CYCLES=4, FIFO_DEPTH=8.
module tb_keypad_event_queue;

   localparam int D = 4;

   logic slowClk = 1'b0;
   logic reset;
   keypad_event_queue_if bus ();

   keypad_event_queue #(
      .DEBOUNCE_CYCLES (D),
      .FIFO_DEPTH      (8),
      .CNT_W           (4)
   ) dut (
      .slowClk (slowClk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 slowClk = ~slowClk;

   int n_pass  = 0;
   int n_total = 0;

   // Event-level reference: queue of codes, sticky overflow, last settled key state.
   logic [7:0] mq[$];
   bit         movf;
   logic [7:0] mkeys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge slowClk);
   endtask

   task automatic peek(input logic sel, output logic [31:0] v);
      bus.en      = 1'b1;
      bus.memRead = 1'b0;
      bus.addrSel = sel;
      #1;
      v      = bus.rdata;
      bus.en = 1'b0;
   endtask

   task automatic cpu_load(input logic sel, output logic [31:0] v);
      bus.en      = 1'b1;
      bus.memRead = 1'b1;
      bus.addrSel = sel;
      #1;
      v = bus.rdata;
      @(negedge slowClk);
      bus.en      = 1'b0;
      bus.memRead = 1'b0;
      bus.addrSel = 1'b0;
   endtask

   task automatic mpush(input logic [7:0] code);
      if (mq.size() == 8) movf = 1'b1;
      else mq.push_back(code);
   endtask

   task automatic model_change(input logic [7:0] nv);
      for (int i = 0; i < 8; i++)
         if (nv[i] && !mkeys[i]) mpush(8'(i));
`ifdef KEYPAD_RELEASE_EVENTS_EN
      for (int i = 0; i < 8; i++)
         if (!nv[i] && mkeys[i]) mpush(8'h80 | 8'(i));
`endif
      mkeys = nv;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [31:0] exp;
      logic [7:0]  drain [8];
      logic [7:0]  nv;
      int          line, len, npop;

      bus.keypad  = 8'h00;
      bus.en      = 1'b0;
      bus.memRead = 1'b0;
      bus.addrSel = 1'b0;
      reset       = 1'b1;

      // Reset state
      step(2);
      peek(1'b0, v); chk("rst_data", v, 32'h0);
      peek(1'b1, v); chk("rst_status", v, 32'h0);
      chk("rst_irq", 32'(bus.irq), 32'h0);
      reset = 1'b0;
      step(1);

      // Clean press of line 3: stable after 2+D cycles, queued one cycle later
      bus.keypad = 8'h08;
      step(5);
      peek(1'b1, v); chk("stable_early", 32'(v[11]), 32'h0);
      step(1);
      peek(1'b1, v); chk("stable_at_6", 32'(v[11]), 32'h1);
      chk("irq_at_6", 32'(bus.irq), 32'h0);
      step(1);
      peek(1'b0, v); chk("data_at_7", v, 32'h103);
      chk("irq_at_7", 32'(bus.irq), 32'h1);
      cpu_load(1'b0, v); chk("pop_key3", v, 32'h103);
      peek(1'b0, v); chk("data_after_pop", v, 32'h0);
      chk("irq_after_pop", 32'(bus.irq), 32'h0);

      // Held key gives no repeat
      step(20);
      peek(1'b1, v); chk("held_status", v, 32'h0000_0800);
      bus.keypad = 8'h00;
      step(D + 4);
`ifdef KEYPAD_RELEASE_EVENTS_EN
      cpu_load(1'b0, v); chk("pop_rel3", v, 32'h183);
`endif
      peek(1'b1, v); chk("after_release", v, 32'h0);

      // Bounce shorter than D on line 5
      bus.keypad = 8'h20;
      step(3);
      bus.keypad = 8'h00;
      step(12);
      peek(1'b1, v); chk("bounce_status", v, 32'h0);
      chk("bounce_irq", 32'(bus.irq), 32'h0);

      // Simultaneous presses of lines 6 and 1
      bus.keypad = 8'h42;
      step(D + 4);
      peek(1'b1, v); chk("simul_count", 32'(v[3:0]), 32'h2);
      cpu_load(1'b0, v); chk("simul_pop1", v, 32'h101);
      cpu_load(1'b0, v); chk("simul_pop2", v, 32'h106);
      bus.keypad = 8'h00;
      step(D + 4);
`ifdef KEYPAD_RELEASE_EVENTS_EN
      cpu_load(1'b0, v); chk("simul_rel1", v, 32'h181);
      cpu_load(1'b0, v); chk("simul_rel2", v, 32'h186);
`endif
      peek(1'b1, v); chk("simul_done", v, 32'h0);

      // Reset while one event is still pending: nothing survives
      bus.keypad = 8'h0C;
      step(D + 3);
      reset      = 1'b1;
      bus.keypad = 8'h00;
      step(1);
      reset = 1'b0;
      peek(1'b1, v); chk("midrst_status", v, 32'h0);
      step(10);
      peek(1'b1, v); chk("midrst_later", v, 32'h0);
      peek(1'b0, v); chk("midrst_data", v, 32'h0);

      // Fill, overflow, clear, push+pop at full, drain, empty pop
      bus.keypad = 8'hFF;
      step(D + 13);
      peek(1'b1, v); chk("fill8", v, 32'h0000_FF08);
      bus.keypad = 8'h01;
      step(D + 12);
      bus.keypad = 8'h03;
      step(D + 4);
      peek(1'b1, v); chk("ovf_set", v, 32'h0001_0308);
      peek(1'b0, v); chk("full_head", v, 32'h100);
      cpu_load(1'b0, v); chk("full_pop", v, 32'h100);
      cpu_load(1'b1, v); chk("stat_read", v, 32'h0001_0307);
      peek(1'b1, v); chk("ovf_cleared", v, 32'h0000_0307);
      bus.keypad = 8'h07;
      step(D + 4);
      peek(1'b1, v); chk("refill", v, 32'h0000_0708);
      bus.keypad = 8'h0F;
      step(D + 2);
      cpu_load(1'b0, v); chk("pop_at_full", v, 32'h101);
      peek(1'b1, v); chk("push_pop_full", v, 32'h0000_0F08);
      drain = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h02, 8'h03};
      for (int k = 0; k < 8; k++) begin
         cpu_load(1'b0, v);
         chk($sformatf("drain%0d", k), v, {23'b0, 1'b1, drain[k]});
      end
      cpu_load(1'b0, v); chk("pop_empty", v, 32'h0);
      peek(1'b1, v); chk("empty_status", v, 32'h0000_0F00);
      bus.keypad = 8'h00;
      step(D + 8);
`ifdef KEYPAD_RELEASE_EVENTS_EN
      for (int k = 0; k < 4; k++) begin
         cpu_load(1'b0, v);
         chk($sformatf("fill_rel%0d", k), v, 32'h180 | 32'(k));
      end
`endif
      peek(1'b1, v); chk("fill_done", v, 32'h0);

      // Randomized key changes with glitches, against the event-level model
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      mq.delete();
      movf  = 1'b0;
      mkeys = 8'h00;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            line = $urandom_range(0, 7);
            len  = $urandom_range(1, D - 1);
            bus.keypad = mkeys ^ (8'h01 << line);
            step(len);
            bus.keypad = mkeys;
            step(3);
         end
         nv = 8'($urandom_range(0, 255));
         bus.keypad = nv;
         model_change(nv);
         step(D + 20);
         peek(1'b1, v);
         chk($sformatf("rnd_status%0d", it), v,
             {15'b0, movf, mkeys, 4'b0, 4'(mq.size())});
         npop = $urandom_range(0, 4);
         for (int k = 0; k < npop; k++) begin
            cpu_load(1'b0, v);
            exp = (mq.size() != 0) ? {23'b0, 1'b1, mq.pop_front()} : 32'h0;
            chk($sformatf("rnd_pop%0d_%0d", it, k), v, exp);
         end
         if ($urandom_range(0, 3) == 0) begin
            cpu_load(1'b1, v);
            chk($sformatf("rnd_stat%0d", it), v,
                {15'b0, movf, mkeys, 4'b0, 4'(mq.size())});
            movf = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
